vm_job_dispatcher: RTL and testbench
====================================

# vm_job_dispatcher

Job scheduler for the eBPF VM slot array in the Keystone coprocessor. It accepts job IDs from the control unit into a small FIFO and dispatches each job to a free, ready VM slot in round-robin order, pulsing that slot's start. It watches the slot's done, error and a programmable timeout, and returns one completion record per job through a valid/ready port. After an error or timeout it resets the slot before reuse.

## Interface
- `NUM_VM_SLOTS`, 8: number of VM slots managed; power of two, ≥2.
- `JOB_ID_WIDTH`, 8: width of job tag.
- `QUEUE_DEPTH`, 4: job FIFO entries; power of two.
- `TIMEOUT_WIDTH`, 16: width of run-cycle counter and timeout limit.

Ports:
- `clk` in 1: single clock for all logic.
- `aresetn` in 1: asynchronous, active-low reset.
- `job_valid` in 1: job offered.
- `job_ready` out 1: FIFO can accept; equals count < QUEUE_DEPTH.
- `job_id` in JOB_ID_WIDTH: tag of the offered job.
- `timeout_cycles` in TIMEOUT_WIDTH: run limit in cycles; 0 disables the timeout.
- `vm_ready` in NUM_VM_SLOTS: slot idle and loaded.
- `vm_done` in NUM_VM_SLOTS: slot finished.
- `vm_error` in NUM_VM_SLOTS: slot faulted.
- `vm_start` out NUM_VM_SLOTS: 1-cycle start pulse.
- `vm_stop` out NUM_VM_SLOTS: 1-cycle stop pulse, issued on timeout.
- `vm_reset` out NUM_VM_SLOTS: 1-cycle slot reset pulse.
- `cmpl_valid` out 1: completion record valid.
- `cmpl_ready` in 1: consumer accepts the record.
- `cmpl_id` out JOB_ID_WIDTH: tag of the completed job.
- `cmpl_slot` out clog2(NUM_VM_SLOTS): slot that ran the job.
- `cmpl_status` out 2: 0 OK, 1 ERROR, 2 TIMEOUT.
- `busy_slots` out NUM_VM_SLOTS: slot state is not IDLE.
- `queue_count` out clog2(QUEUE_DEPTH)+1: FIFO occupancy.

## Operation
- Job FIFO: a push occurs on `job_valid && job_ready`. A full FIFO does not bypass, so `job_ready`=0 even if a pop happens in the same cycle. Simultaneous push and pop leaves the count unchanged.
- Per-slot FSM states: IDLE, RUN, PEND, RST.
  - IDLE → RUN on dispatch. The job ID is latched, the run counter is cleared, and `vm_start[i]` pulses.
  - RUN: the counter increments each cycle and saturates at its maximum.
    - `vm_error[i]` → PEND with status ERROR. Error wins over a simultaneous done.
    - `vm_done[i]` → PEND with status OK.
    - If neither fires and `timeout_cycles`≠0 and counter+1 == `timeout_cycles` → PEND with status TIMEOUT, and `vm_stop[i]` pulses the same cycle.
  - PEND: waits for its completion record to be accepted. Then status OK → IDLE; ERROR or TIMEOUT → RST with `vm_reset[i]` pulsed on entry.
  - RST → IDLE once `vm_ready[i]`=1, no earlier than 1 cycle after the pulse.
- Dispatch, at most one per cycle:
  - Eligible slots are those in IDLE with `vm_ready[i]`=1.
  - The pick is the first eligible slot at or after `rr_ptr`, modulo NUM_VM_SLOTS.
  - Dispatch requires FIFO non-empty. The FIFO pops the same cycle.
  - `rr_ptr` becomes the granted slot + 1, wrapping from NUM_VM_SLOTS-1 to 0.
- Completion, at most one per cycle:
  - Fixed output register. It loads from the PEND slot chosen by a separate round-robin pointer when `cmpl_valid`=0, or in the same cycle the current record is accepted.
  - The record holds stable while `cmpl_valid && !cmpl_ready`.
  - A slot leaves PEND in the cycle its record is accepted.
- Inputs `vm_done`, `vm_error` and `vm_ready` are ignored for a slot outside the states that consume them.
- Reset: FIFO empty, all slots IDLE, both pointers 0, and all outputs 0 except `job_ready`=1. Reset mid-run abandons jobs and produces no completions. Slots are not pulsed by this block's reset.

## Timing
- Job pushed at cycle t into an empty FIFO with an eligible slot → `vm_start` asserted in cycle t+1. All outputs are registered.
- `vm_done` sampled at cycle t with the output register free → `cmpl_valid` at t+1.
- Back-to-back: one dispatch per cycle while the queue and slots are available. Completion throughput is 1 per cycle with `cmpl_ready` held high.
- Timeout: with `timeout_cycles`=N, `vm_stop` fires N cycles after `vm_start`, with `vm_start` counted as cycle 0.
- `timeout_cycles` is sampled every cycle; changing it mid-run takes effect immediately.

## Test plan
- Reset state: all outputs 0 and `job_ready`=1. Push 4 jobs (IDs 0x10–0x13) with all `vm_ready`=1 → `vm_start` one-hot on slots 0,1,2,3 in consecutive cycles; `queue_count` peaks at 1.
- FIFO full: all `vm_ready`=0; push IDs 1–5 → 4 accepted, `job_ready`=0 at count 4, ID 5 held. Raise `vm_ready[5]` → job 1 goes to slot 5.
- Completion ordering: slots 2 and 6 assert `vm_done` in the same cycle with `cmpl_ready`=0 for 3 cycles → the first record is held stable, then both are delivered in pointer order with status 0. Slots return to IDLE with no `vm_reset`.
- Error with done: slot 3 asserts `vm_error` and `vm_done` in the same cycle → status 1. `vm_reset[3]` pulses on acceptance, and the slot stays busy until `vm_ready[3]`.
- Timeout: `timeout_cycles`=20, no done → `vm_stop` on cycle 20 after start, status 2, then `vm_reset`. Repeat with `timeout_cycles`=0 for 70000 cycles → no stop.
- Async reset mid-run (3 slots RUN, 2 queued) → all outputs 0 immediately. After release, a new job dispatches to slot 0.

Source files
------------

// File: rtl/vm_job_dispatcher.sv
// vm_job_dispatcher: queues job IDs, dispatches them round-robin to ready VM slots and returns one completion record per job
module vm_job_dispatcher #(
    parameter int NUM_VM_SLOTS  = 8,
    parameter int JOB_ID_WIDTH  = 8,
    parameter int QUEUE_DEPTH   = 4,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            aresetn,
    input  logic                            job_valid,
    output logic                            job_ready,
    input  logic [JOB_ID_WIDTH-1:0]         job_id,
    input  logic [TIMEOUT_WIDTH-1:0]        timeout_cycles,
    input  logic [NUM_VM_SLOTS-1:0]         vm_ready,
    input  logic [NUM_VM_SLOTS-1:0]         vm_done,
    input  logic [NUM_VM_SLOTS-1:0]         vm_error,
    output logic [NUM_VM_SLOTS-1:0]         vm_start,
    output logic [NUM_VM_SLOTS-1:0]         vm_stop,
    output logic [NUM_VM_SLOTS-1:0]         vm_reset,
    output logic                            cmpl_valid,
    input  logic                            cmpl_ready,
    output logic [JOB_ID_WIDTH-1:0]         cmpl_id,
    output logic [$clog2(NUM_VM_SLOTS)-1:0] cmpl_slot,
    output logic [1:0]                      cmpl_status,
    output logic [NUM_VM_SLOTS-1:0]         busy_slots,
    output logic [$clog2(QUEUE_DEPTH):0]    queue_count
);
    localparam int SW = $clog2(NUM_VM_SLOTS);
    localparam int QW = $clog2(QUEUE_DEPTH);
    localparam logic [QW:0] DEPTH = (QW+1)'(QUEUE_DEPTH);
    localparam logic [1:0] ST_OK = 2'd0, ST_ERR = 2'd1, ST_TO = 2'd2;

    typedef enum logic [1:0] {IDLE, RUN, PEND, RST} slot_state_t;

    slot_state_t              state       [NUM_VM_SLOTS];
    slot_state_t              state_nxt   [NUM_VM_SLOTS];
    logic [TIMEOUT_WIDTH-1:0] run_cnt     [NUM_VM_SLOTS];
    logic [TIMEOUT_WIDTH-1:0] run_cnt_nxt [NUM_VM_SLOTS];
    logic [JOB_ID_WIDTH-1:0]  slot_id     [NUM_VM_SLOTS];
    logic [JOB_ID_WIDTH-1:0]  slot_id_nxt [NUM_VM_SLOTS];
    logic [1:0]               slot_st     [NUM_VM_SLOTS];
    logic [1:0]               slot_st_nxt [NUM_VM_SLOTS];
    logic [JOB_ID_WIDTH-1:0]  fifo_mem    [QUEUE_DEPTH];

    logic [NUM_VM_SLOTS-1:0] start_nxt, stop_nxt, reset_nxt, eligible, pend_free;
    logic [QW-1:0]           wr_ptr, rd_ptr;
    logic [SW-1:0]           rr_ptr, cmpl_ptr, disp_idx, pick_idx, scan;
    logic                    disp_found, pick_found, dispatch, push, accept, load;

    assign job_ready = queue_count < DEPTH;
    assign push      = job_valid && job_ready;
    assign dispatch  = disp_found && queue_count != '0;
    assign accept    = cmpl_valid && cmpl_ready;
    assign load      = !cmpl_valid || cmpl_ready;

    always_comb begin
        eligible   = '0;
        pend_free  = '0;
        busy_slots = '0;
        for (int i = 0; i < NUM_VM_SLOTS; i++) begin
            eligible[i]   = state[i] == IDLE && vm_ready[i];
            pend_free[i]  = state[i] == PEND && !(cmpl_valid && cmpl_slot == SW'(i));
            busy_slots[i] = state[i] != IDLE;
        end
    end

    always_comb begin
        disp_found = 1'b0;
        disp_idx   = '0;
        pick_found = 1'b0;
        pick_idx   = '0;
        scan       = '0;
        for (int k = 0; k < NUM_VM_SLOTS; k++) begin
            scan = rr_ptr + SW'(k);
            if (!disp_found && eligible[scan]) begin
                disp_found = 1'b1;
                disp_idx   = scan;
            end
            scan = cmpl_ptr + SW'(k);
            if (!pick_found && pend_free[scan]) begin
                pick_found = 1'b1;
                pick_idx   = scan;
            end
        end
    end

    always_comb begin
        start_nxt = '0;
        stop_nxt  = '0;
        reset_nxt = '0;
        for (int i = 0; i < NUM_VM_SLOTS; i++) begin
            state_nxt[i]   = state[i];
            run_cnt_nxt[i] = run_cnt[i];
            slot_id_nxt[i] = slot_id[i];
            slot_st_nxt[i] = slot_st[i];
            case (state[i])
                IDLE: if (dispatch && disp_idx == SW'(i)) begin
                    state_nxt[i]   = RUN;
                    run_cnt_nxt[i] = '0;
                    slot_id_nxt[i] = fifo_mem[rd_ptr];
                    start_nxt[i]   = 1'b1;
                end
                RUN: begin
                    run_cnt_nxt[i] = run_cnt[i] == '1 ? run_cnt[i] : run_cnt[i] + 1'b1;
                    if (vm_error[i] || vm_done[i]) begin
                        state_nxt[i]   = PEND;
                        slot_st_nxt[i] = vm_error[i] ? ST_ERR : ST_OK;
                    end else if (timeout_cycles != '0 && run_cnt[i] + 1'b1 == timeout_cycles) begin
                        state_nxt[i]   = PEND;
                        slot_st_nxt[i] = ST_TO;
                        stop_nxt[i]    = 1'b1;
                    end
                end
                PEND: if (accept && cmpl_slot == SW'(i)) begin
                    state_nxt[i] = slot_st[i] == ST_OK ? IDLE : RST;
                    reset_nxt[i] = slot_st[i] != ST_OK;
                end
                default: if (vm_ready[i] && !vm_reset[i]) state_nxt[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_VM_SLOTS; i++) begin
                state[i]   <= IDLE;
                run_cnt[i] <= '0;
                slot_id[i] <= '0;
                slot_st[i] <= ST_OK;
            end
            vm_start    <= '0;
            vm_stop     <= '0;
            vm_reset    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            queue_count <= '0;
            rr_ptr      <= '0;
            cmpl_ptr    <= '0;
            cmpl_valid  <= 1'b0;
            cmpl_id     <= '0;
            cmpl_slot   <= '0;
            cmpl_status <= '0;
        end else begin
            for (int i = 0; i < NUM_VM_SLOTS; i++) begin
                state[i]   <= state_nxt[i];
                run_cnt[i] <= run_cnt_nxt[i];
                slot_id[i] <= slot_id_nxt[i];
                slot_st[i] <= slot_st_nxt[i];
            end
            vm_start <= start_nxt;
            vm_stop  <= stop_nxt;
            vm_reset <= reset_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (dispatch) begin
                rd_ptr <= rd_ptr + 1'b1;
                rr_ptr <= disp_idx + 1'b1;
            end
            if (push != dispatch) queue_count <= push ? queue_count + 1'b1 : queue_count - 1'b1;
            if (load) begin
                cmpl_valid <= pick_found;
                if (pick_found) begin
                    cmpl_id     <= slot_id[pick_idx];
                    cmpl_slot   <= pick_idx;
                    cmpl_status <= slot_st[pick_idx];
                    cmpl_ptr    <= pick_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= job_id;
    end
endmodule

// File: tb/tb_vm_job_dispatcher.sv
// tb_vm_job_dispatcher: table-driven and directed checks of the VM job dispatcher
module tb_vm_job_dispatcher;
    logic        clk = 1'b0;
    logic        aresetn, job_valid, job_ready, cmpl_valid, cmpl_ready;
    logic [7:0]  job_id, vm_ready, vm_done, vm_error, vm_start, vm_stop, vm_reset, cmpl_id, busy_slots;
    logic [15:0] timeout_cycles;
    logic [2:0]  cmpl_slot, queue_count;
    logic [1:0]  cmpl_status;
    int checks = 0, failures = 0;

    typedef struct {
        logic       jv;
        logic [7:0] jid;
        logic [7:0] vr;
        logic [7:0] e_start;
        logic [7:0] e_busy;
        logic [2:0] e_qc;
        logic       e_jr;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;

    vm_job_dispatcher dut (
        .clk(clk), .aresetn(aresetn), .job_valid(job_valid), .job_ready(job_ready), .job_id(job_id),
        .timeout_cycles(timeout_cycles), .vm_ready(vm_ready), .vm_done(vm_done), .vm_error(vm_error),
        .vm_start(vm_start), .vm_stop(vm_stop), .vm_reset(vm_reset), .cmpl_valid(cmpl_valid),
        .cmpl_ready(cmpl_ready), .cmpl_id(cmpl_id), .cmpl_slot(cmpl_slot), .cmpl_status(cmpl_status),
        .busy_slots(busy_slots), .queue_count(queue_count)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        job_valid = 1'b0;
        job_id = '0;
        vm_ready = '0;
        vm_done = '0;
        vm_error = '0;
        cmpl_ready = 1'b1;
        timeout_cycles = '0;
        repeat (2) cyc();
        aresetn = 1'b1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_start"}, vm_start, 0);
        chk({tag, "_stop"}, vm_stop, 0);
        chk({tag, "_reset"}, vm_reset, 0);
        chk({tag, "_cvalid"}, cmpl_valid, 0);
        chk({tag, "_cid"}, cmpl_id, 0);
        chk({tag, "_cslot"}, cmpl_slot, 0);
        chk({tag, "_cstatus"}, cmpl_status, 0);
        chk({tag, "_busy"}, busy_slots, 0);
        chk({tag, "_qcount"}, queue_count, 0);
        chk({tag, "_jready"}, job_ready, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        vecs[0] = '{1'b1, 8'h10, 8'hFF, 8'h00, 8'h00, 3'd1, 1'b1};
        vecs[1] = '{1'b1, 8'h11, 8'hFF, 8'h01, 8'h01, 3'd1, 1'b1};
        vecs[2] = '{1'b1, 8'h12, 8'hFF, 8'h02, 8'h03, 3'd1, 1'b1};
        vecs[3] = '{1'b1, 8'h13, 8'hFF, 8'h04, 8'h07, 3'd1, 1'b1};
        vecs[4] = '{1'b0, 8'h00, 8'hFF, 8'h08, 8'h0F, 3'd0, 1'b1};
        vecs[5] = '{1'b0, 8'h00, 8'hFF, 8'h00, 8'h0F, 3'd0, 1'b1};

        do_reset();
        chk_idle_outputs("rst");

        for (int r = 0; r < 6; r++) begin
            job_valid = vecs[r].jv;
            job_id = vecs[r].jid;
            vm_ready = vecs[r].vr;
            cyc();
            chk($sformatf("t1_start[%0d]", r), vm_start, vecs[r].e_start);
            chk($sformatf("t1_busy[%0d]", r), busy_slots, vecs[r].e_busy);
            chk($sformatf("t1_qcount[%0d]", r), queue_count, vecs[r].e_qc);
            chk($sformatf("t1_jready[%0d]", r), job_ready, vecs[r].e_jr);
        end

        do_reset();
        for (int k = 1; k <= 4; k++) begin
            job_valid = 1'b1;
            job_id = 8'(k);
            cyc();
        end
        chk("t2_full_qcount", queue_count, 4);
        chk("t2_full_jready", job_ready, 0);
        job_id = 8'd5;
        cyc();
        chk("t2_hold_qcount", queue_count, 4);
        vm_ready = 8'h20;
        cyc();
        chk("t2_start5", vm_start, 8'h20);
        chk("t2_pop_qcount", queue_count, 3);
        chk("t2_jready_again", job_ready, 1);
        cyc();
        chk("t2_push5_qcount", queue_count, 4);
        job_valid = 1'b0;
        vm_done = 8'h20;
        cyc();
        chk("t2_cvalid_latency", cmpl_valid, 0);
        vm_done = '0;
        cyc();
        chk("t2_cvalid", cmpl_valid, 1);
        chk("t2_cid", cmpl_id, 8'h01);
        chk("t2_cslot", cmpl_slot, 5);
        chk("t2_cstatus", cmpl_status, 0);

        do_reset();
        vm_ready = 8'hFF;
        for (int k = 0; k < 7; k++) begin
            job_valid = 1'b1;
            job_id = 8'h20 + 8'(k);
            cyc();
        end
        job_valid = 1'b0;
        cyc();
        vm_ready = '0;
        chk("t3_busy_all", busy_slots, 8'h7F);
        cmpl_ready = 1'b0;
        vm_done = 8'h44;
        cyc();
        vm_done = '0;
        cyc();
        chk("t3_first_valid", cmpl_valid, 1);
        chk("t3_first_slot", cmpl_slot, 2);
        chk("t3_first_id", cmpl_id, 8'h22);
        chk("t3_first_status", cmpl_status, 0);
        for (int h = 0; h < 3; h++) begin
            cyc();
            chk($sformatf("t3_hold_valid[%0d]", h), cmpl_valid, 1);
            chk($sformatf("t3_hold_slot[%0d]", h), cmpl_slot, 2);
            chk($sformatf("t3_hold_id[%0d]", h), cmpl_id, 8'h22);
        end
        cmpl_ready = 1'b1;
        cyc();
        chk("t3_second_valid", cmpl_valid, 1);
        chk("t3_second_slot", cmpl_slot, 6);
        chk("t3_second_id", cmpl_id, 8'h26);
        chk("t3_second_status", cmpl_status, 0);
        chk("t3_busy_after_first", busy_slots, 8'h7B);
        chk("t3_no_reset_a", vm_reset, 0);
        cyc();
        chk("t3_drained", cmpl_valid, 0);
        chk("t3_busy_after_second", busy_slots, 8'h3B);
        chk("t3_no_reset_b", vm_reset, 0);

        do_reset();
        vm_ready = 8'h08;
        job_valid = 1'b1;
        job_id = 8'h33;
        cyc();
        job_valid = 1'b0;
        cyc();
        chk("t4_start3", vm_start, 8'h08);
        vm_ready = '0;
        cmpl_ready = 1'b0;
        vm_error = 8'h08;
        vm_done = 8'h08;
        cyc();
        vm_error = '0;
        vm_done = '0;
        cyc();
        chk("t4_cvalid", cmpl_valid, 1);
        chk("t4_cstatus", cmpl_status, 1);
        chk("t4_cslot", cmpl_slot, 3);
        chk("t4_cid", cmpl_id, 8'h33);
        chk("t4_no_reset_yet", vm_reset, 0);
        cmpl_ready = 1'b1;
        cyc();
        chk("t4_reset_pulse", vm_reset, 8'h08);
        chk("t4_cvalid_clear", cmpl_valid, 0);
        chk("t4_busy_rst", busy_slots, 8'h08);
        cyc();
        chk("t4_reset_single", vm_reset, 0);
        chk("t4_busy_wait_a", busy_slots, 8'h08);
        cyc();
        chk("t4_busy_wait_b", busy_slots, 8'h08);
        vm_ready = 8'h08;
        cyc();
        chk("t4_idle", busy_slots, 0);

        do_reset();
        timeout_cycles = 16'd20;
        vm_ready = 8'h01;
        job_valid = 1'b1;
        job_id = 8'h44;
        cyc();
        job_valid = 1'b0;
        cyc();
        chk("t5_start", vm_start, 8'h01);
        cnt = 0;
        for (int k = 1; k < 20; k++) begin
            cyc();
            if (vm_stop != 0) cnt++;
        end
        chk("t5_no_early_stop", cnt, 0);
        cyc();
        chk("t5_stop_at_20", vm_stop, 8'h01);
        cyc();
        chk("t5_stop_single", vm_stop, 0);
        chk("t5_cvalid", cmpl_valid, 1);
        chk("t5_cstatus", cmpl_status, 2);
        chk("t5_cslot", cmpl_slot, 0);
        chk("t5_cid", cmpl_id, 8'h44);
        cyc();
        chk("t5_reset_pulse", vm_reset, 8'h01);
        for (int w = 0; w < 6 && busy_slots != 0; w++) cyc();
        chk("t5_back_idle", busy_slots, 0);

        do_reset();
        vm_ready = 8'h01;
        job_valid = 1'b1;
        job_id = 8'h45;
        cyc();
        job_valid = 1'b0;
        cyc();
        chk("t5z_start", vm_start, 8'h01);
        cnt = 0;
        repeat (70000) begin
            cyc();
            if (vm_stop != 0 || cmpl_valid) cnt++;
        end
        chk("t5z_no_stop", cnt, 0);
        chk("t5z_still_busy", busy_slots, 8'h01);

        do_reset();
        vm_ready = 8'h07;
        for (int k = 0; k < 5; k++) begin
            job_valid = 1'b1;
            job_id = 8'h60 + 8'(k);
            cyc();
        end
        job_valid = 1'b0;
        cyc();
        chk("t6_busy_pre", busy_slots, 8'h07);
        chk("t6_qcount_pre", queue_count, 2);
        #3;
        aresetn = 1'b0;
        #1;
        chk_idle_outputs("t6_async");
        cyc();
        aresetn = 1'b1;
        vm_ready = 8'hFF;
        job_valid = 1'b1;
        job_id = 8'h55;
        cyc();
        job_valid = 1'b0;
        cyc();
        chk("t6_restart_slot0", vm_start, 8'h01);
        chk("t6_no_cmpl", cmpl_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
